// File: rtl/beta_pkg.sv
// Shared Beta datapath constants and types used by the register file.
package beta_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t XP_ADDR   = reg_addr_t'(30);
    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(31);

endpackage

// File: rtl/reg_file_if.sv
// Decode/write-back side bundle of the register file: two read ports, one write port.
interface reg_file_if;
    import beta_pkg::*;

    logic      RegWrite;
    logic      RegDst;
    reg_addr_t ra;
    reg_addr_t rb;
    reg_addr_t rc;
    word_t     wdata;
    word_t     radata;
    word_t     rbdata;

    modport master (
        output RegWrite, RegDst, ra, rb, rc, wdata,
        input  radata, rbdata
    );

    modport slave (
        input  RegWrite, RegDst, ra, rb, rc, wdata,
        output radata, rbdata
    );

endinterface

// File: rtl/reg_file.sv
// 32 x 32 Beta register file: combinational read ports A/B, one synchronous write port,
// R31 reads as zero and swallows writes, RegDst steers the write to the exception pointer.
module reg_file
    import beta_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    reg_file_if.slave   bus
);

    word_t     regs [NUM_REGS];
    reg_addr_t waddr;

    assign waddr = bus.RegDst ? XP_ADDR : bus.rc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.RegWrite && (waddr != ZERO_ADDR)) begin
            regs[waddr] <= bus.wdata;
        end
    end

    // No write bypass: a read of the register being written sees the old value until the edge.
    always_comb begin
        bus.radata = '0;
        bus.rbdata = '0;
        if (rst_n) begin
            if (bus.ra != ZERO_ADDR) bus.radata = regs[bus.ra];
            if (bus.rb != ZERO_ADDR) bus.rbdata = regs[bus.rb];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized check of reg_file against an array model of R0..R31.
module tb_reg_file;
    import beta_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] model [32];

    reg_file_if bus ();

    reg_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expect_read(input logic [4:0] a);
        return (a == 5'd31) ? 32'h0 : model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_a"}, bus.radata, expect_read(bus.ra));
        check({tag, "_b"}, bus.rbdata, expect_read(bus.rb));
    endtask

    // Advance one rising edge, applying the write rules to the model with the inputs held at the edge.
    task automatic tick();
        logic       we;
        logic [4:0] wa;
        logic [31:0] wd;
        we = bus.RegWrite;
        wa = bus.RegDst ? 5'd30 : bus.rc;
        wd = bus.wdata;
        @(posedge clk);
        if (rst_n && we && wa != 5'd31) model[wa] = wd;
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic dst, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] c, input logic [31:0] d);
        bus.RegWrite = we;
        bus.RegDst   = dst;
        bus.ra       = a;
        bus.rb       = b;
        bus.rc       = c;
        bus.wdata    = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        clear_model();
        drive(1'b1, 1'b0, 5'd3, 5'd3, 5'd3, 32'h5555_5555);
        // Writes are blocked while reset is held.
        @(negedge clk);
        #1;
        check("rst_hold_a", bus.radata, 32'h0);
        check("rst_hold_b", bus.rbdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_blocked_write", bus.radata, 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd30, 5'd0, 32'h0);
        check_reads("post_rst");
        check("post_rst_r3", dut.bus.radata, 32'h0);

        // Async reset mid-cycle clears a freshly written register.
        drive(1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF);
        tick();
        bus.RegWrite = 1'b0;
        #1;
        check("r5_deadbeef", bus.radata, 32'hDEAD_BEEF);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("async_rst_a", bus.radata, 32'h0);
        check("async_rst_b", bus.rbdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("r5_after_rst", bus.radata, 32'h0);

        // Basic write: old value in the write cycle, new value after the edge.
        drive(1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 32'h1234_5678);
        #1;
        check("rdw_old_value", bus.radata, 32'h0);
        tick();
        bus.RegWrite = 1'b0;
        #1;
        check("basic_a", bus.radata, 32'h1234_5678);
        check("basic_b", bus.rbdata, 32'h1234_5678);

        // R31 swallows writes.
        drive(1'b1, 1'b0, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF);
        tick();
        bus.RegWrite = 1'b0;
        #1;
        check("r31_a", bus.radata, 32'h0);
        check("r31_b", bus.rbdata, 32'h0);

        // RegDst routes the write to R30 and leaves rc untouched.
        drive(1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 32'h0000_0777);
        tick();
        drive(1'b1, 1'b1, 5'd30, 5'd7, 5'd7, 32'hA5A5_A5A5);
        tick();
        bus.RegWrite = 1'b0;
        #1;
        check("xp_r30", bus.radata, 32'hA5A5_A5A5);
        check("xp_r7_unchanged", bus.rbdata, 32'h0000_0777);

        // RegWrite=0 leaves state alone, even with inputs wiggling mid-cycle.
        drive(1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 32'hCAFE_F00D);
        tick();
        bus.rc = 5'd5;
        bus.wdata = 32'h0BAD_0BAD;
        #1;
        check("wr_disable_r9", bus.radata, 32'h0);
        bus.ra = 5'd5;
        #1;
        check("wr_disable_r5", bus.radata, 32'h1234_5678);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            check_reads("rand");
            tick();
        end

        // Full sweep: unique pattern in every writable register.
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'(i), 32'h1000_0000 + i);
            tick();
        end
        bus.RegWrite = 1'b0;
        for (int i = 0; i < 31; i++) begin
            bus.ra = 5'(i);
            bus.rb = 5'(30 - i);
            #1;
            check("sweep_a", bus.radata, 32'h1000_0000 + i);
            check("sweep_b", bus.rbdata, 32'h1000_0000 + (30 - i));
        end
        bus.ra = 5'd31;
        bus.rb = 5'd31;
        #1;
        check("sweep_r31_a", bus.radata, 32'h0);
        check("sweep_r31_b", bus.rbdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
